// File: rtl/pipe_register_file.sv
// Pipeline register file: two combinational read ports, E/M write ports and per-register
// pending-write counters with a sticky overflow flag. Optional same-cycle bypass: REGFILE_BYPASS_EN.
module pipe_register_file #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NREGS  = 15,
  parameter int unsigned CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  input  logic [3:0]        dstE,
  input  logic [3:0]        dstM,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic              wr_en,
  input  logic              resv_en,
  input  logic [3:0]        resv_d0,
  input  logic [3:0]        resv_d1,
  output logic              busyA,
  output logic              busyB,
  output logic              ovf_err
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [CNT_W-1:0]  cnt_q  [NREGS];
  logic [CNT_W-1:0]  cnt_d  [NREGS];
  logic              ovf_q, ovf_d;
  logic [NREGS-1:0]  inc, dec;

  // IDs are matched against each valid index, so RNONE and IDs >= NREGS never hit.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      inc[i] = resv_en && (resv_d0 == 4'(i) || resv_d1 == 4'(i));
      dec[i] = wr_en && (dstE == 4'(i) || dstM == 4'(i));
    end
  end

  always_comb begin
    regs_d = regs_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (wr_en && dstM == 4'(i)) begin
        regs_d[i] = valM;
      end else if (wr_en && dstE == 4'(i)) begin
        regs_d[i] = valE;
      end
      // Simultaneous reserve and release cancel out.
      if (inc[i] && !dec[i]) begin
        if (&cnt_q[i]) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else if (dec[i] && !inc[i] && cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= DATA_W'(i);
        cnt_q[i]  <= '0;
      end
      ovf_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  always_comb begin
    valA  = '0;
    valB  = '0;
    busyA = 1'b0;
    busyB = 1'b0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (srcA == 4'(i)) begin
        valA  = regs_q[i];
        busyA = cnt_q[i] != '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && dstM == srcA) begin
          valA = valM;
        end else if (wr_en && dstE == srcA) begin
          valA = valE;
        end
        if (dec[i] && !inc[i] && cnt_q[i] == CNT_W'(1)) begin
          busyA = 1'b0;
        end
`endif
      end
      if (srcB == 4'(i)) begin
        valB  = regs_q[i];
        busyB = cnt_q[i] != '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && dstM == srcB) begin
          valB = valM;
        end else if (wr_en && dstE == srcB) begin
          valB = valE;
        end
        if (dec[i] && !inc[i] && cnt_q[i] == CNT_W'(1)) begin
          busyB = 1'b0;
        end
`endif
      end
    end
  end

  assign ovf_err = ovf_q;

endmodule

// File: tb/tb_pipe_register_file.sv
// Bench for pipe_register_file: directed scenarios followed by random traffic, all checked
// against an array-based reference model of registers and pending counts.
module tb_pipe_register_file;

  localparam int unsigned DW   = 64;
  localparam int          NR   = 15;
  localparam int          CMAX = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    srcA, srcB, dstE, dstM, resv_d0, resv_d1;
  logic [DW-1:0] valA, valB, valE, valM;
  logic          wr_en, resv_en, busyA, busyB, ovf_err;

  pipe_register_file #(.DATA_W(DW), .NREGS(NR), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
    .dstE(dstE), .dstM(dstM), .valE(valE), .valM(valM), .wr_en(wr_en),
    .resv_en(resv_en), .resv_d0(resv_d0), .resv_d1(resv_d1),
    .busyA(busyA), .busyB(busyB), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] m_reg [16];
  int            m_cnt [16];
  bit            m_ovf;

  function automatic bit m_valid(input int id);
    return id < NR;
  endfunction

  function automatic bit m_inc(input int i);
    return resv_en && m_valid(i) && (int'(resv_d0) == i || int'(resv_d1) == i);
  endfunction

  function automatic bit m_dec(input int i);
    return wr_en && m_valid(i) && (int'(dstE) == i || int'(dstM) == i);
  endfunction

  function automatic logic [DW-1:0] exp_val(input int id);
    if (!m_valid(id)) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && int'(dstM) == id) return valM;
    if (wr_en && int'(dstE) == id) return valE;
`endif
    return m_reg[id];
  endfunction

  function automatic bit exp_busy(input int id);
    if (!m_valid(id)) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (m_cnt[id] == 1 && m_dec(id) && !m_inc(id)) return 1'b0;
`endif
    return m_cnt[id] > 0;
  endfunction

  // Applies one rising edge to the model using the currently driven inputs.
  function automatic void model_edge();
    int delta [16];
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_reg[i] = DW'(i);
        m_cnt[i] = 0;
      end
      m_ovf = 1'b0;
      return;
    end
    for (int i = 0; i < 16; i++) delta[i] = int'(m_inc(i)) - int'(m_dec(i));
    if (wr_en) begin
      if (m_valid(int'(dstE))) m_reg[dstE] = valE;
      if (m_valid(int'(dstM))) m_reg[dstM] = valM;
    end
    for (int i = 0; i < 16; i++) begin
      if (delta[i] > 0) begin
        if (m_cnt[i] == CMAX) m_ovf = 1'b1;
        else m_cnt[i]++;
      end else if (delta[i] < 0 && m_cnt[i] > 0) begin
        m_cnt[i]--;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    #1;
    if (chk_en) begin
      chk("valA", valA, exp_val(int'(srcA)));
      chk("valB", valB, exp_val(int'(srcB)));
      chk("busyA", DW'(busyA), DW'(exp_busy(int'(srcA))));
      chk("busyB", DW'(busyB), DW'(exp_busy(int'(srcB))));
      chk("ovf_err", DW'(ovf_err), DW'(m_ovf));
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; wr_en = 1'b0; resv_en = 1'b0;
    dstE = 4'hF; dstM = 4'hF; resv_d0 = 4'hF; resv_d1 = 4'hF;
    valE = '0; valM = '0;
  endtask

  initial begin
    idle();
    srcA = 4'd3; srcB = 4'd14;
    rst = 1'b1;
    tick();
    chk_en = 1'b1;

    // Reset values
    idle(); srcA = 4'd3; srcB = 4'd14; #1;
    chk("rst_valA", valA, 64'd3);
    chk("rst_valB", valB, 64'd14);
    chk("rst_busy", DW'({busyA, busyB, ovf_err}), '0);
    tick();

    // E and M to the same register: M wins
    wr_en = 1'b1; dstE = 4'd2; valE = 64'hAA; dstM = 4'd2; valM = 64'hBB;
    tick();
    idle(); srcA = 4'd2; srcB = 4'hF; #1;
    chk("m_prio", valA, 64'hBB);
    chk("rnone_rd", valB, '0);
    tick();

    // Saturation of counter 5 and release by three writes
    srcA = 4'd5;
    resv_en = 1'b1; resv_d0 = 4'd5;
    repeat (4) tick();
    idle(); #1;
    chk("ovf_set", DW'(ovf_err), 64'd1);
    chk("busy5", DW'(busyA), 64'd1);
    wr_en = 1'b1; dstE = 4'd5; valE = 64'h1234;
    repeat (3) tick();
    idle(); #1;
    chk("busy5_clr", DW'(busyA), 64'd0);
    chk("ovf_sticky", DW'(ovf_err), 64'd1);
    tick();

    // Reserve and release in the same cycle
    srcA = 4'd6;
    resv_en = 1'b1; resv_d0 = 4'd6;
    tick();
    wr_en = 1'b1; dstE = 4'd6; valE = 64'h66;
    tick();
    idle(); #1;
    chk("cnt6_hold", DW'(busyA), 64'd1);
    tick();

    // Same-cycle read of a register being written, then a suppressed write
    srcA = 4'd7; wr_en = 1'b1; dstE = 4'd7; valE = 64'h55; #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass7", valA, 64'h55);
`else
    chk("nobypass7", valA, 64'd7);
`endif
    tick();
    wr_en = 1'b0; valE = 64'h99;
    tick();
    idle(); #1;
    chk("wr_en0", valA, 64'h55);
    tick();

    // Reset with reservations pending; same-cycle activity discarded
    resv_en = 1'b1; resv_d0 = 4'd8; resv_d1 = 4'd9;
    tick();
    rst = 1'b1; wr_en = 1'b1; dstE = 4'd8; valE = 64'hFFFF; resv_d0 = 4'd10;
    tick();
    idle();
    for (int i = 0; i < 16; i++) begin
      srcA = 4'(i); srcB = 4'(15 - i); #1;
      chk("rst2_val", valA, (i < NR) ? DW'(i) : '0);
      chk("rst2_busy", DW'({busyA, busyB}), '0);
      chk("rst2_ovf", DW'(ovf_err), '0);
      tick();
    end

    // Random traffic
    repeat (400) begin
      rst     = ($urandom_range(0, 59) == 0);
      srcA    = 4'($urandom_range(0, 15));
      srcB    = 4'($urandom_range(0, 15));
      dstE    = 4'($urandom_range(0, 15));
      dstM    = ($urandom_range(0, 4) == 0) ? dstE : 4'($urandom_range(0, 15));
      valE    = {$urandom, $urandom};
      valM    = {$urandom, $urandom};
      wr_en   = ($urandom_range(0, 3) != 0);
      resv_en = $urandom_range(0, 1) == 1;
      resv_d0 = 4'($urandom_range(0, 15));
      resv_d1 = ($urandom_range(0, 4) == 0) ? resv_d0 : 4'($urandom_range(0, 15));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
